// File: rtl/fixed_to_float_seq.sv
// Signed fixed-point to IEEE-754 single converter with an iterative normaliser.
// Each cycle in NORM the magnitude shifts left one bit until its MSB is set.
module fixed_to_float_seq #(
  parameter int WIDTH = 22,
  parameter int FRAC  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  output logic             done,
  output logic [31:0]      result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE on an enabled edge; done pulses for
  // one enabled cycle when result is valid, and result then holds until the next done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [8:0] EXP_INIT = 9'(WIDTH - 1 - FRAC + 127);

  state_t           state;
  logic [WIDTH-1:0] mag;
  logic [8:0]       exp_r;
  logic             sign;

  logic [WIDTH-1:0] mag_in;
  logic [22:0]      frac;
  logic             unused_exp_msb;

  // Most negative input negates to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_in = dataa[WIDTH-1] ? -dataa : dataa;
  end

  // Hidden bit mag[WIDTH-1] is dropped; the rest is left-aligned in the fraction.
  generate
    if (WIDTH <= 24) begin : g_frac_pad
      always_comb begin
        frac = 23'(mag[WIDTH-2:0]) << (24 - WIDTH);
      end
    end else begin : g_frac_trim
      always_comb begin
        frac = mag[WIDTH-2 -: 23];
      end
    end
  endgenerate

  assign unused_exp_msb = exp_r[8];
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 32'h0000_0000;
      mag    <= '0;
      exp_r  <= 9'd0;
      sign   <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= dataa[WIDTH-1];
            mag   <= mag_in;
            exp_r <= EXP_INIT;
            if (mag_in == '0) begin
              result <= 32'h0000_0000;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[WIDTH-1]) begin
            result <= {sign, exp_r[7:0], frac};
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            mag   <= mag << 1;
            exp_r <= exp_r - 9'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Bench for fixed_to_float_seq: directed and random conversions checked every
// cycle against a real-arithmetic model of value and latency.
module tb_fixed_to_float_seq;

  localparam int W = 22;
  localparam int F = 20;

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          start;
  logic [W-1:0]  dataa;
  logic          done;
  logic [31:0]   result;
  logic [1:0]    state_dbg;

  int            n_cmp;
  int            n_err;
  int            cyc;
  logic [31:0]   held_res;
  logic [31:0]   exp_q[$];
  int            exp_cyc_q[$];

  fixed_to_float_seq #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
    .done(done), .result(result), .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: value = dataa / 2^F, encoded through the double format.
  function automatic logic [31:0] model_f(input logic [W-1:0] d);
    int          v;
    real         r;
    logic [63:0] b;
    int          e;
    v = int'($signed(d));
    if (v == 0) return 32'h0000_0000;
    r = $itor(v) / (2.0 ** F);
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic int model_lat(input logic [W-1:0] d);
    int v;
    int m;
    int msb;
    v = int'($signed(d));
    if (v == 0) return 1;
    m = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if ((m >> i) & 1) msb = i;
    return 2 + (W - 1 - msb);
  endfunction

  // Scoreboard / compare process: done and result checked every cycle.
  always @(negedge clk) begin
    logic exp_done;
    exp_done = (exp_cyc_q.size() != 0) && (cyc == exp_cyc_q[0]);
    if (exp_done) begin
      held_res = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
    end
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("result", result, held_res);
  end

  // Driver: called just after a negedge with DUT idle.
  task automatic conv(input logic [W-1:0] d, input logic [31:0] er, input int lat,
                      input int stall, input bit poke);
    int t;
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = d;
    @(posedge clk); #1;
    exp_q.push_back(er);
    exp_cyc_q.push_back(cyc + lat - 1 + stall);
    start = 1'b0;
    dataa = W'($urandom());
    if (stall > 0) begin
      clk_en = 1'b0;
      repeat (stall) @(posedge clk);
      #1 clk_en = 1'b1;
    end
    if (poke) begin
      start = 1'b1;
      dataa = 22'h100000;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
    end
    t = 0;
    while (exp_cyc_q.size() != 0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (exp_cyc_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: conversion of %h not retired", d);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    held_res = 32'h0000_0000;
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'h0000_0000);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] d;
    int           stall;
    n_cmp    = 0;
    n_err    = 0;
    held_res = 32'h0000_0000;
    reset    = 1'b0;
    clk_en   = 1'b1;
    start    = 1'b0;
    dataa    = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 do_reset();

    // Pin the model with hand-computed values.
    chk("model_one", model_f(22'h100000), 32'h3F800000);
    chk("model_neg2", model_f(22'h200000), 32'hC0000000);
    chk("model_min", model_f(22'h000001), 32'h35800000);
    chk("model_nhalf", model_f(22'h380000), 32'hBF000000);
    chk("model_lat_one", 32'(model_lat(22'h100000)), 32'd3);
    chk("model_lat_min", 32'(model_lat(22'h000001)), 32'd23);
    chk("model_lat_zero", 32'(model_lat(22'h000000)), 32'd1);

    // Directed conversions with literal expectations.
    conv(22'h100000, 32'h3F800000, 3, 0, 1'b0);
    conv(22'h200000, 32'hC0000000, 2, 0, 1'b0);
    conv(22'h000000, 32'h00000000, 1, 0, 1'b0);
    conv(22'h000001, 32'h35800000, 23, 0, 1'b0);
    conv(22'h380000, 32'hBF000000, 4, 0, 1'b0);
    conv(22'h0C0000, 32'h3F400000, 4, 5, 1'b0);
    conv(22'h000001, 32'h35800000, 23, 0, 1'b1);

    // start with clk_en low in IDLE must not be accepted.
    clk_en = 1'b0;
    start  = 1'b1;
    dataa  = 22'h100000;
    repeat (3) @(negedge clk);
    #1 start = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Reset mid-NORM drops the conversion.
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = 22'h000001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 do_reset();
    conv(22'h100000, 32'h3F800000, 3, 0, 1'b0);

    // Randomized conversions against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       d = '0;
        1:       d = 22'h200000;
        default: begin
          d = W'($urandom() >> $urandom_range(10, 31));
          if ($urandom_range(0, 1) == 1) d = -d;
        end
      endcase
      stall = (d != '0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      conv(d, model_f(d), model_lat(d), stall, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        clk_en = 1'b0;
        start  = $urandom_range(0, 1) == 1;
        dataa  = W'($urandom());
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1 start = 1'b0;
        clk_en = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
